// File: rtl/load_unit_if.sv
// Load unit bus bundle: request/response handshake toward the datapath and
// the word-read port toward data memory.
interface load_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  // master: datapath + memory side; slave: the load unit itself
  modport master (
    output req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_req, mem_addr
  );
  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_req, mem_addr
  );
endinterface

// File: rtl/load_unit.sv
// Multicycle RISC-V load reader: one or two word reads per load, misaligned
// accesses crossing a word boundary are stitched, then sign/zero-extended.
module load_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  load_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           lo_q;
  logic [31:0]           rsp_data_q;
  logic                  req_ready_q, rsp_valid_q, rsp_err_q, mem_req_q;
  logic                  split;
  logic [ADDR_WIDTH-1:0] word_b;

  function automatic logic legal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'({hi, lo} >> {off, 3'b000});
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extract = {24'h0, sh[7:0]};
      3'b101:  extract = {16'h0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // halfword at offset 3, or any misaligned word, spills into the next word
  assign split  = (f3_q[1:0] == 2'b01 && addr_q[1:0] == 2'b11) ||
                  (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
  assign word_b = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      mem_addr_q  <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q      <= bus.req_addr;
          f3_q        <= bus.req_funct3;
          req_ready_q <= 1'b0;
          if (legal(bus.req_funct3)) begin
            state      <= RD0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          end else begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end
        end
        RD0: state <= WAIT0;
        WAIT0: if (bus.mem_rvalid) begin
          lo_q <= bus.mem_rdata;
          if (split) begin
            state      <= RD1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= word_b;
          end else begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= extract(32'h0, bus.mem_rdata, addr_q[1:0], f3_q);
          end
        end
        RD1: state <= WAIT1;
        WAIT1: if (bus.mem_rvalid) begin
          state       <= DONE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= extract(bus.mem_rdata, lo_q, addr_q[1:0], f3_q);
        end
        DONE: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed vector bench for load_unit with a cycle-accurate memory model
// of configurable latency.
module tb_load_unit;
  logic clk = 1'b0;
  logic reset;

  load_unit_if #(.ADDR_WIDTH(32)) bus ();
  load_unit #(.ADDR_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    int          lat;
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          nreq;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] f3, input int lat,
                              input logic [31:0] data, input logic err, input int cyc,
                              input int nreq, input logic [31:0] a0, input logic [31:0] a1);
    vec_t v;
    v.addr = addr; v.f3 = f3; v.lat = lat; v.data = data; v.err = err;
    v.cyc = cyc; v.nreq = nreq; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h4433_2211;
      32'h0000_0104: mem_word = 32'h8877_6655;
      32'hFFFF_FFFC: mem_word = 32'hDDCC_BBAA;
      32'h0000_0000: mem_word = 32'h0000_0011;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is #1 past a rising edge with the DUT idle; that cycle is cycle 0.
  task automatic run(input vec_t v, input string tag);
    int          cyc, due, nreq;
    logic        pend, got;
    logic [31:0] paddr;
    logic [31:0] a0, a1;
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = v.addr;
    bus.req_funct3 = v.f3;
    bus.mem_rvalid = 1'b1;               // stray strobe while idle
    bus.mem_rdata  = 32'hA5A5_A5A5;
    cyc = 0; due = 0; nreq = 0; pend = 1'b0; got = 1'b0;
    paddr = '0; a0 = '0; a1 = '0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      // keep req_valid up with a bogus request; it must be ignored while busy
      bus.req_addr   = v.addr ^ 32'h8;
      bus.req_funct3 = 3'b011;
      bus.mem_rvalid = pend && cyc == due;
      bus.mem_rdata  = (pend && cyc == due) ? mem_word(paddr) : 32'hA5A5_A5A5;
      if (pend && cyc == due) pend = 1'b0;
      if (bus.mem_req) begin
        chk({tag, " one outstanding"}, 32'(pend), 32'd0);
        if (nreq == 0) a0 = bus.mem_addr;
        if (nreq == 1) a1 = bus.mem_addr;
        nreq++;
        pend  = 1'b1;
        due   = cyc + v.lat;
        paddr = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b0;
      end
    end
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk({tag, " rsp seen"}, 32'(got), 32'd1);
    chk({tag, " rsp cycle"}, 32'(cyc), 32'(v.cyc));
    chk({tag, " rsp_data"}, bus.rsp_data, v.data);
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
    chk({tag, " nreq"}, 32'(nreq), 32'(v.nreq));
    if (v.nreq >= 1) chk({tag, " addr0"}, a0, v.a0);
    if (v.nreq >= 2) chk({tag, " addr1"}, a1, v.a1);
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " held"}, bus.rsp_data, v.data);
    chk({tag, " ready back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_funct3 = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    //         addr          f3    L  data          err cyc n  a0            a1
    vt.push_back(mk(32'h100,      3'b010, 3, 32'h4433_2211, 0, 5, 1, 32'h100,      32'h0));
    vt.push_back(mk(32'h103,      3'b000, 3, 32'h0000_0044, 0, 5, 1, 32'h100,      32'h0));
    vt.push_back(mk(32'h107,      3'b000, 3, 32'hFFFF_FF88, 0, 5, 1, 32'h104,      32'h0));
    vt.push_back(mk(32'h107,      3'b100, 3, 32'h0000_0088, 0, 5, 1, 32'h104,      32'h0));
    vt.push_back(mk(32'h106,      3'b001, 3, 32'hFFFF_8877, 0, 5, 1, 32'h104,      32'h0));
    vt.push_back(mk(32'h106,      3'b101, 3, 32'h0000_8877, 0, 5, 1, 32'h104,      32'h0));
    vt.push_back(mk(32'h102,      3'b010, 3, 32'h6655_4433, 0, 9, 2, 32'h100,      32'h104));
    vt.push_back(mk(32'h103,      3'b001, 3, 32'h0000_5544, 0, 9, 2, 32'h100,      32'h104));
    vt.push_back(mk(32'hFFFF_FFFE, 3'b010, 3, 32'h0011_DDCC, 0, 9, 2, 32'hFFFF_FFFC, 32'h0));
    vt.push_back(mk(32'h100,      3'b011, 3, 32'h0,         1, 1, 0, 32'h0,        32'h0));
    vt.push_back(mk(32'h100,      3'b010, 3, 32'h4433_2211, 0, 5, 1, 32'h100,      32'h0));
    vt.push_back(mk(32'h101,      3'b101, 3, 32'h0000_3322, 0, 5, 1, 32'h100,      32'h0));
    vt.push_back(mk(32'h102,      3'b001, 3, 32'h0000_4433, 0, 5, 1, 32'h100,      32'h0));
    vt.push_back(mk(32'h104,      3'b111, 3, 32'h0,         1, 1, 0, 32'h0,        32'h0));
    vt.push_back(mk(32'h101,      3'b010, 1, 32'h5544_3322, 0, 5, 2, 32'h100,      32'h104));
    vt.push_back(mk(32'h104,      3'b000, 5, 32'h0000_0055, 0, 7, 1, 32'h104,      32'h0));
    vt.push_back(mk(32'h103,      3'b010, 2, 32'h7766_5544, 0, 7, 2, 32'h100,      32'h104));

    #12;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_data", bus.rsp_data, 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) run(vt[i], $sformatf("vec%0d", i));

    // reset while waiting for the first read word
    bus.req_valid = 1'b1; bus.req_addr = 32'h100; bus.req_funct3 = 3'b010;
    @(posedge clk); #1;                                  // cycle 1
    bus.req_valid = 1'b0;
    chk("mid mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;                                  // cycle 2, WAIT0
    reset = 1'b1;
    #1;
    chk("mid req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid rsp_data", bus.rsp_data, 32'h0);
    chk("mid rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("mid mem_req0", 32'(bus.mem_req), 32'd0);
    chk("mid mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;                                  // cycle 3
    @(posedge clk); #1;                                  // cycle 4: late data
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h4433_2211;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      if (bus.rsp_valid || bus.mem_req) seen = 1'b1;
    end
    chk("late rvalid ignored", 32'(seen), 32'd0);
    run(mk(32'h100, 3'b100, 3, 32'h0000_0011, 0, 5, 1, 32'h100, 32'h0), "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_unit.md
# load_unit

Multicycle load-side memory reader for the processor datapath. It accepts one load request at a time (byte address plus RISC-V load funct3) and issues one or two word-aligned reads to data memory, handling misaligned accesses that cross a word boundary. It then extracts, aligns and sign- or zero-extends the result, and returns it with a one-cycle valid pulse. The datapath captures that pulse into its enabled result register.

## Interface
- ADDR_WIDTH, 32: byte address width; data width is fixed at 32.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  load request present
- req_ready  out  1  high when a request can be accepted (state IDLE)
- req_addr  in  ADDR_WIDTH  byte address of the load
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal
- rsp_valid  out  1  one-cycle pulse; response is valid
- rsp_data  out  32  loaded, extended value; held until the next response
- rsp_err  out  1  qualifies rsp_valid; high for an illegal funct3
- mem_req  out  1  one-cycle memory read strobe
- mem_addr  out  ADDR_WIDTH  word-aligned read address (low 2 bits are always 0)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data, little-endian

## Operation
- States: IDLE, RD0, WAIT0, RD1, WAIT1, DONE.
- IDLE
  - req_ready=1.
  - On req_valid, capture req_addr and req_funct3.
  - Legal funct3: go to RD0.
  - Illegal funct3: go to DONE with the error flag set; no memory access.
- Word addresses: A = addr & ~3; B = A + 4, modulo 2^ADDR_WIDTH (wraps to 0).
- Offset: off = addr[1:0]. Size in bytes: 1 for LB/LBU, 2 for LH/LHU, 4 for LW.
- Split access when off + size > 4:
  - LH/LHU with off=3.
  - LW with off=1, 2 or 3.
- RD0: mem_req=1, mem_addr=A; go to WAIT0.
- WAIT0: on mem_rvalid, capture mem_rdata as the low word. Then go to RD1 if split, else DONE.
- RD1: mem_req=1, mem_addr=B; go to WAIT1.
- WAIT1: on mem_rvalid, capture mem_rdata as the high word; go to DONE.
- DONE
  - rsp_valid=1 for exactly one cycle; go to IDLE.
  - Extraction: shifted = {high, low} >> (8*off); the high word is 0 if not split. Take the low size bytes.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
  - rsp_data and rsp_err are registered and update on entry to DONE.
  - Illegal funct3: rsp_data=0 and rsp_err=1.
- mem_rvalid is ignored in every state other than WAIT0 and WAIT1.
- Only one read is outstanding at a time.
- req_valid is ignored outside IDLE.
- Reset, asynchronous, at any time including mid-transaction:
  - State goes to IDLE; captured words are cleared; the response is dropped.
  - A late mem_rvalid after reset is ignored.
- Reset values:
  - req_ready=1 (IDLE)
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - mem_req=0, mem_addr=0

## Timing
- Memory latency L >= 1: mem_rvalid arrives L cycles after the mem_req cycle. L may vary per read.
- Request handshake in cycle 0 (req_valid & req_ready).
- Aligned or non-split load: mem_req in cycle 1, mem_rvalid in cycle 1+L, rsp_valid in cycle 2+L.
- Split load: second mem_req in cycle 2+L, mem_rvalid in cycle 2+2L, rsp_valid in cycle 3+2L.
- Illegal funct3: rsp_valid in cycle 1; mem_req never asserts.
- req_ready is low from cycle 1 until the cycle after rsp_valid. Back-to-back throughput is therefore one load per (3+L) cycles when non-split.
- mem_req and mem_addr are driven from state and captured registers. mem_addr holds its last value when mem_req=0.

## Test plan
Memory model: word at 0x100 = 0x44332211, word at 0x104 = 0x88776655, L=3 unless stated.
- LW at 0x100 -> mem_req once at cycle 1 with mem_addr=0x100; rsp_valid at cycle 5; rsp_data=0x44332211; rsp_err=0.
- Byte loads:
  - LB at 0x103 -> 0x00000044.
  - LB at 0x107 -> 0xFFFFFF88.
  - LBU at 0x107 -> 0x00000088.
  - LH at 0x106 -> 0xFFFF8877.
  - LHU at 0x106 -> 0x00008877.
- Split loads:
  - LW at 0x102 -> reads 0x100 then 0x104; rsp_data=0x66554433 at cycle 9.
  - LH at 0x103 -> 0x00005544.
- Wrap-around: LW at 0xFFFFFFFE, with word 0xFFFFFFFC = 0xDDCCBBAA and word 0x0 = 0x00000011 -> mem_addr 0xFFFFFFFC then 0x00000000; rsp_data=0x0011DDCC.
- Illegal funct3=011 at 0x100 -> rsp_valid=1 and rsp_err=1 at cycle 1; rsp_data=0; mem_req stays 0. A following LW at 0x100 returns 0x44332211 with rsp_err=0.
- Reset mid-transaction:
  - Assert reset in WAIT0 -> req_ready=1 and all other outputs 0 immediately.
  - The late mem_rvalid is ignored and no rsp_valid appears.
  - A new LBU at 0x100 then returns 0x00000011.
